// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the data memory responder.
package dmem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 4;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the control unit and the data memory.
interface data_mem_responder_if;

  logic       readEn;
  logic       writeEn;
  logic [7:0] address;
  logic [7:0] writeData;
  logic [7:0] readData;
  logic       BUSY;

  modport master (
    output readEn, writeEn, address, writeData,
    input  readData, BUSY
  );

  modport slave (
    input  readEn, writeEn, address, writeData,
    output readData, BUSY
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTHx8 storage: synchronous write, registered read, asynchronous clear-all.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with BUSY stall handshake toward the program counter.
// Optional zero-stall repeated load: define DMEM_FASTHIT_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input logic                 CLK,
  input logic                 RESET,
  data_mem_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [AW-1:0] wrap_addr(input logic [7:0] a);
    return AW'(32'(a) % DEPTH);
  endfunction

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
  op_t           op_q;
  logic          req;
  op_t           req_op;
  logic          fast_hit;
  logic          last_edge;
  logic          mem_we;
  logic          mem_re;

  assign req       = bus.readEn | bus.writeEn;
  assign req_op    = bus.writeEn ? OP_WR : OP_RD;
  assign last_edge = (state == ST_ACCESS) && (cnt == 4'd0);
  assign mem_we    = last_edge && (op_q == OP_WR);
  assign mem_re    = last_edge && (op_q == OP_RD);

`ifdef DMEM_FASTHIT_EN
  logic          tag_vld;
  logic [AW-1:0] tag_addr;

  // Tag follows the value currently held in readData; any store may alias it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tag_vld  <= 1'b0;
      tag_addr <= '0;
    end else if (mem_re) begin
      tag_vld  <= 1'b1;
      tag_addr <= addr_q;
    end else if (mem_we) begin
      tag_vld  <= 1'b0;
    end
  end

  assign fast_hit = (state == ST_IDLE) && bus.readEn && !bus.writeEn &&
                    tag_vld && (tag_addr == wrap_addr(bus.address));
`else
  assign fast_hit = 1'b0;
`endif

  // BUSY is raised combinationally in IDLE so the PC holds on the accept edge.
  assign bus.BUSY = ((state == ST_IDLE) && req && !fast_hit) || (state == ST_ACCESS);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (fast_hit) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ACCESS;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) state <= ST_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == ST_IDLE) && req) begin
      addr_q  <= wrap_addr(bus.address);
      wdata_q <= bus.writeData;
      op_q    <= req_op;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (bus.readData)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder (default LATENCY=4, DEPTH=256).
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  data_mem_responder_if bus ();

  data_mem_responder dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [8:0] a;
    logic [7:0] d;
    int         busy;
    logic [7:0] rdat;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and hold it until the DONE cycle, like the control unit.
  task automatic run_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] d, output int busy_n,
                            output logic [7:0] rdv, output bit to);
    @(negedge clk);
    bus.readEn    = rd;
    bus.writeEn   = wr;
    bus.address   = a;
    bus.writeData = d;
    busy_n = 0;
    to     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!bus.BUSY) break;
      busy_n++;
      @(negedge clk);
    end
    if (busy_n >= 40) to = 1'b1;
    if (busy_n == 0) begin
      @(negedge clk);
      #1;
    end
    rdv = bus.readData;
    bus.readEn  = 1'b0;
    bus.writeEn = 1'b0;
  endtask

  int         bn;
  logic [7:0] rv;
  bit         tmo;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst           = 1'b1;
    bus.readEn    = 1'b0;
    bus.writeEn   = 1'b0;
    bus.address   = '0;
    bus.writeData = '0;

    tbl[0]  = '{1'b0, 1'b1, 9'd2,   8'd32,  5, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 9'd2,   8'd0,   5, 8'd32};
    tbl[2]  = '{1'b0, 1'b1, 9'd6,   8'd8,   5, 8'd32};
    tbl[3]  = '{1'b1, 1'b0, 9'd6,   8'd0,   5, 8'd8};
    tbl[4]  = '{1'b1, 1'b0, 9'd4,   8'd0,   5, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 9'd44,  8'h77,  5, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 9'd300, 8'd0,   5, 8'h77};
    tbl[7]  = '{1'b1, 1'b1, 9'd9,   8'h55,  5, 8'h77};
    tbl[8]  = '{1'b1, 1'b0, 9'd9,   8'd0,   5, 8'h55};
    tbl[9]  = '{1'b0, 1'b1, 9'd255, 8'hFE,  5, 8'h55};
    tbl[10] = '{1'b1, 1'b0, 9'd255, 8'd0,   5, 8'hFE};

    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", bus.BUSY, 0);
    check("reset_rdata", bus.readData, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].a[7:0], tbl[i].d, bn, rv, tmo);
      check($sformatf("vec%0d_timeout", i), int'(tmo), 0);
      check($sformatf("vec%0d_busy_edges", i), bn, tbl[i].busy);
      check($sformatf("vec%0d_rdata", i), rv, tbl[i].rdat);
    end

    // After retirement: back in IDLE, no re-trigger, readData held over idle cycles
    repeat (3) @(negedge clk);
    #1;
    check("idle_busy", bus.BUSY, 0);
    check("idle_rdata_hold", bus.readData, 8'hFE);

    // Reset pulsed in the middle of a store's ACCESS phase
    @(negedge clk);
    bus.writeEn   = 1'b1;
    bus.address   = 8'd3;
    bus.writeData = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midacc_busy_before", bus.BUSY, 1);
    rst         = 1'b1;
    bus.writeEn = 1'b0;
    #1;
    check("midacc_busy_rst", bus.BUSY, 0);
    check("midacc_rdata_rst", bus.readData, 0);
    @(negedge clk);
    rst = 1'b0;
    run_access(1'b1, 1'b0, 8'd3, 8'd0, bn, rv, tmo);
    check("post_rst_rd3_busy", bn, 5);
    check("post_rst_rd3_data", rv, 0);
    run_access(1'b1, 1'b0, 8'd2, 8'd0, bn, rv, tmo);
    check("post_rst_rd2_cleared", rv, 0);

    // Repeated load of one address, then a store invalidates any shortcut
    run_access(1'b0, 1'b1, 8'd5, 8'h3C, bn, rv, tmo);
    check("wr5_busy", bn, 5);
    run_access(1'b1, 1'b0, 8'd5, 8'd0, bn, rv, tmo);
    check("rd5_first_busy", bn, 5);
    check("rd5_first_data", rv, 8'h3C);
    run_access(1'b1, 1'b0, 8'd5, 8'd0, bn, rv, tmo);
`ifdef DMEM_FASTHIT_EN
    check("rd5_second_busy", bn, 0);
`else
    check("rd5_second_busy", bn, 5);
`endif
    check("rd5_second_data", rv, 8'h3C);
    run_access(1'b0, 1'b1, 8'd7, 8'h11, bn, rv, tmo);
    check("wr7_busy", bn, 5);
    check("wr7_rdata_hold", rv, 8'h3C);
    run_access(1'b1, 1'b0, 8'd5, 8'd0, bn, rv, tmo);
    check("rd5_after_wr_busy", bn, 5);
    check("rd5_after_wr_data", rv, 8'h3C);
    run_access(1'b1, 1'b0, 8'd7, 8'd0, bn, rv, tmo);
    check("rd7_data", rv, 8'h11);

    @(negedge clk);
    #1;
    check("final_idle_busy", bus.BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle 8-bit data memory that answers the load/store requests issued by the processor control unit. It sits between the control unit (readEn/writeEn/address), the ALU result bus (store data) and the register-file write mux (load data). It raises BUSY to stall the program counter for the duration of every access. It is the responder side of the BUSY stall handshake used by the programCounter.

## Interface
Parameters:
- DEPTH, 256, number of 8-bit words; the address is taken modulo DEPTH.
- LATENCY, 4, number of ACCESS-state cycles per access; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  reset, asynchronous, active-high.
- readEn  input  1  load request; level, held by the control unit until the instruction retires.
- writeEn  input  1  store request; level, same holding rule.
- address  input  8  word address; sampled on the accept edge.
- writeData  input  8  store data; sampled on the accept edge.
- readData  output  8  load result; registered; holds the last completed read.
- BUSY  output  1  stall to the PC; high while a request is pending or in progress.

## Operation
- States are IDLE, ACCESS and DONE.
- IDLE: if readEn|writeEn, BUSY=1 combinationally in the same cycle. At the next rising edge, capture address, writeData and the op into registers, load cnt=LATENCY-1, and go to ACCESS.
- Both enables high: treat as a write; the read is ignored.
- ACCESS: BUSY=1. Enable inputs are ignored; the captured values are used. Each edge decrements cnt. On the edge where cnt==0:
  - a write stores writeData into mem[addr];
  - a read loads readData from mem[addr];
  - the state goes to DONE.
- DONE: BUSY=0 and requests are ignored, because the enables of the retiring instruction are still high. Next edge goes to IDLE unconditionally.
- readData changes only on read completion. It is unchanged by writes and by idle cycles.
- Address arithmetic: 8-bit, index = address mod DEPTH, no fault on overflow.
- RESET (any time, including mid-ACCESS):
  - state goes to IDLE and BUSY goes to 0;
  - readData=0 and cnt=0;
  - all memory words are cleared to 0;
  - an in-flight write is discarded.

## Timing
- BUSY is high at exactly LATENCY+1 consecutive rising edges per access: the accept edge plus LATENCY ACCESS edges. The PC therefore holds for LATENCY+1 edges.
- Read data is valid from the edge entering DONE onward. It is stable at the following falling edge, where the register file writes.
- Write data is visible to a read accepted at any edge after the write's DONE state.
- Back-to-back memory instructions: the second request is accepted from IDLE at the edge after DONE. There is no lost request.
- Reset values: BUSY=0, readData=8'h00.

## Configuration
- DMEM_FASTHIT_EN defined:
  - adds a one-entry last-read tag (valid and address), set on every read completion;
  - a read accepted in IDLE whose address matches a valid tag goes IDLE→DONE with BUSY=0 throughout, i.e. a zero-stall load. readData already holds the value;
  - any write completion or RESET clears the valid bit.
- DMEM_FASTHIT_EN undefined: no tag logic; every access takes the full LATENCY path.

## Structure
- Package dmem_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - the default LATENCY and DEPTH constants;
  - the op encoding (OP_RD, OP_WR).
- Sub-module dmem_array: DEPTH×8 storage with a synchronous write port, a synchronous read into a readData register, and an asynchronous clear-all on RESET. The FSM, counter and tag stay in the top module.

## Test plan
- Reset, then writeEn with addr=2 and data=32 at LATENCY=4 → BUSY high at 5 edges, then low. Reading addr 2 later returns 32.
- Store 8 to addr 6, then load addr 6 immediately after → readData=8 on DONE. The PC advances exactly once per instruction, with no re-trigger in DONE.
- Load from the never-written addr 4 → readData=0. Load addr 300 (8-bit wrap → 44) → reads mem[44].
- readEn and writeEn both high, addr=9, data=0x55 → write performed, readData unchanged, mem[9]=0x55.
- RESET pulsed during ACCESS of a write of 0xAA to addr 3 → BUSY=0 and readData=0 immediately. A later read of addr 3 returns 0.
- With DMEM_FASTHIT_EN: load addr 5 twice → the second load has BUSY=0 on all edges. Store to any address, then load addr 5 → full-latency stall again.
